// File: rtl/hash_msg_block_loader.sv
// rtl/hash_msg_block_loader.sv - SHA-256 message padder emitting 512-bit blocks from a BPB-byte beat stream
// Optional macro START_SYNC_EN: IDLE accepts beats and a START_BYTE in byte 0 starts the message.
module hash_msg_block_loader #(
    parameter int unsigned BPB        = 1,
    parameter int unsigned CNT_W      = 32,
    parameter logic [7:0]  START_BYTE = 8'hAA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [8*BPB-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [3:0]       i_last_bytes,
    output logic             o_in_ready,
    output logic [511:0]     o_blk_data,
    output logic             o_blk_valid,
    input  logic             i_blk_ready,
    output logic             o_blk_first,
    output logic             o_blk_last,
    output logic             o_busy
);

`ifdef START_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, PAD, EMIT} state_e;

    state_e           state_q;
    logic [511:0]     buf_q;
    logic [511:0]     load_blk;
    logic [511:0]     pad_blk;
    logic [6:0]       ptr_q;
    logic [6:0]       ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             last_q;
    logic             pad_pend_q;
    logic             len_pend_q;
    logic [3:0]       nbytes;
    logic [63:0]      bit_len;
    logic             beat;
    logic             start_hit;

    assign beat      = i_valid && (state_q == LOAD);
    assign start_hit = i_start || (SYNC_EN && i_valid && (i_data[8*BPB-1 -: 8] == START_BYTE));
    assign nbytes    = (!i_last) ? 4'(BPB) : ((i_last_bytes > 4'(BPB)) ? 4'(BPB) : i_last_bytes);
    assign ptr_d     = ptr_q + {3'b000, nbytes};
    assign bit_len   = 64'(cnt_q) << 3;

    assign o_in_ready  = (state_q == LOAD) || (SYNC_EN && (state_q == IDLE));
    assign o_blk_data  = buf_q;
    assign o_blk_valid = (state_q == EMIT);
    assign o_blk_first = first_q && (state_q == EMIT);
    assign o_blk_last  = last_q && (state_q == EMIT);
    assign o_busy      = (state_q != IDLE);

    // Bytes of a short final beat beyond its valid count are stored as zero.
    always_comb begin
        load_blk = buf_q;
        for (int j = 0; j < int'(BPB); j++) begin
            if (int'(ptr_q) + j < 64)
                load_blk[511 - 8*(int'(ptr_q) + j) -: 8] =
                    (j < int'(nbytes)) ? i_data[8*BPB-1-8*j -: 8] : 8'h00;
        end
    end

    // A length-only block carries no 0x80 marker; otherwise marker at ptr, zeros after.
    always_comb begin
        pad_blk = '0;
        if (!len_pend_q) begin
            for (int i = 0; i < 64; i++) begin
                if (i < int'(ptr_q))
                    pad_blk[511-8*i -: 8] = buf_q[511-8*i -: 8];
                else if (i == int'(ptr_q))
                    pad_blk[511-8*i -: 8] = 8'h80;
            end
        end
        if (len_pend_q || (ptr_q <= 7'd55))
            pad_blk[63:0] = bit_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_hit) begin
                        state_q    <= LOAD;
                        buf_q      <= '0;
                        ptr_q      <= '0;
                        cnt_q      <= '0;
                        first_q    <= 1'b1;
                        last_q     <= 1'b0;
                        pad_pend_q <= 1'b0;
                        len_pend_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        buf_q <= load_blk;
                        ptr_q <= ptr_d;
                        cnt_q <= cnt_q + CNT_W'(nbytes);
                        if (ptr_d == 7'd64) begin
                            state_q    <= EMIT;
                            last_q     <= 1'b0;
                            pad_pend_q <= i_last;
                        end else if (i_last) begin
                            state_q <= PAD;
                        end
                    end
                end
                PAD: begin
                    buf_q   <= pad_blk;
                    state_q <= EMIT;
                    if (len_pend_q || (ptr_q <= 7'd55)) begin
                        last_q     <= 1'b1;
                        len_pend_q <= 1'b0;
                    end else begin
                        last_q     <= 1'b0;
                        len_pend_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (i_blk_ready) begin
                        first_q <= 1'b0;
                        if (last_q) begin
                            state_q <= IDLE;
                        end else if (pad_pend_q) begin
                            // Message filled the block exactly: padding starts a fresh block at byte 0.
                            pad_pend_q <= 1'b0;
                            ptr_q      <= '0;
                            buf_q      <= '0;
                            state_q    <= PAD;
                        end else if (len_pend_q) begin
                            state_q <= PAD;
                        end else begin
                            ptr_q   <= '0;
                            buf_q   <= '0;
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
